ram_s2psbe1c_arb: RTL and testbench
===================================

Name: ram_s2psbe1c_arb

Overview:
Round-robin arbiter that shares one simple-dual-port byte-enable RAM (1 write port, 1 registered read port, 1-cycle read latency) between N_REQ requesters. Each cycle it grants at most one write and, independently, at most one read. It drives the RAM ports and routes read data back to the requester that issued the read. It sits between bus/agent front-ends and the RAM instance, which lives outside this block.

Parameters:
N_REQ, 2, number of requesters (>=2)
BYTE_WIDTH, 8, bits per byte lane
BYTES_IN_WORD, 4, byte lanes per word
WORD_COUNT, 256, RAM depth; ADDR_WIDTH = $clog2(WORD_COUNT), WORD_WIDTH = BYTE_WIDTH*BYTES_IN_WORD (localparams)

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  N_REQ  request valid per requester
req_ready_o  out  N_REQ  request accepted this cycle (combinational grant)
req_we_i  in  N_REQ  1=write, 0=read
req_be_i  in  N_REQ x BYTES_IN_WORD  byte enables (writes only)
req_addr_i  in  N_REQ x ADDR_WIDTH  word address
req_wdata_i  in  N_REQ x WORD_WIDTH  write data
rsp_valid_o  out  N_REQ  read data valid for requester i
rsp_data_o  out  WORD_WIDTH  read data, shared by all requesters; qualify with rsp_valid_o
ram_we_o  out  1  RAM write enable
ram_be_o  out  BYTES_IN_WORD  RAM byte enables
ram_waddr_o  out  ADDR_WIDTH  RAM write address
ram_wdata_o  out  WORD_WIDTH  RAM write data
ram_raddr_o  out  ADDR_WIDTH  RAM read address
ram_rdata_i  in  WORD_WIDTH  RAM registered read data (valid 1 cycle after address)

Behaviour:
- Clock clk_i. Reset rst_i is synchronous, active-high.
- Classes: write candidates = req_valid_i & req_we_i; read candidates = req_valid_i & ~req_we_i. Each class has its own round-robin arbiter.
- Grant: the first candidate at or after the class priority pointer, searching in increasing index order with wrap from N_REQ-1 to 0.
- req_ready_o[i] = write grant[i] | read grant[i]. It is combinational from req_valid_i, req_we_i and the pointers, and never depends on ram_rdata_i.
- Transfer occurs on req_valid_i & req_ready_o. A requester with valid held and no grant keeps its request stable; no timeout.
- Pointer update: on a grant to i, that class's pointer becomes (i+1) mod N_REQ. With no grant, the pointer holds.
- Write path (combinational): ram_we_o = any write grant; ram_be_o, ram_waddr_o and ram_wdata_o are muxed from the granted requester.
- Write path, idle: when there is no write grant, ram_we_o=0 and ram_be_o=0. ram_waddr_o and ram_wdata_o are don't-care but must be deterministic: drive 0.
- be=0 write: accepted and forwarded with ram_we_o=1; the RAM changes no bytes.
- Read path: ram_raddr_o = granted reader's address, or 0 when idle. A 1-cycle registered tag rd_sel_q records the read grant (one-hot, 0 if none).
- Read response: rsp_valid_o = rd_sel_q (registered, exactly one cycle after acceptance). rsp_data_o = ram_rdata_i passed through combinationally.
- Throughput: one write plus one read per cycle, from different requesters. A requester issues at most one command per cycle.
- Read and write to the same address in the same cycle: the read returns pre-write (old) data. The arbiter does not forward.
- No response backpressure: the requester must accept rsp_valid_o.
- Reset values: rd_sel_q=0 (so rsp_valid_o=0); both pointers=0, giving requester 0 top priority in the first cycle after reset.
- Reset mid-operation: any read accepted in the cycle rst_i is high is discarded, with no rsp_valid_o afterwards. Any write combinationally forwarded in that cycle may still reach the RAM; the RAM is not reset.
- Assertions, disabled during rst_i:
  - req_valid_i has no X.
  - A valid request has no X on req_we_i or req_addr_i.
  - A valid write has no X on req_be_i.
  - req_ready_o within each class is onehot0.
  - rsp_valid_o is onehot0.

Decomposition:
- Package ram_arb_pkg:
  - Typedef req_t {we, be, addr, wdata}, parameterized via the module's localparams or passed as type parameters.
  - Function rr_pick(onehot pointer, candidate mask) returning a one-hot grant.
- Sub-module rr_arbiter #(N):
  - Ports: clk_i, rst_i, req_i[N], gnt_o[N].
  - Contains the pointer register and the pointer update.
  - Instantiated twice, once for writes and once for reads.
- Top module: muxes, rd_sel_q and assertions only.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, all valid=0 -> rsp_valid_o=0, ram_we_o=0, ram_be_o=0, req_ready_o=0.
- Simple write/read, req0: write addr 0x10, be=4'b0101, wdata 0xAABBCCDD; next cycle read 0x10 -> ram_we_o=1 with be 0101; rsp_valid_o[0]=1 two cycles after the write, with RAM model data 0x00BB00DD over initial 0.
- Fairness: both requesters hold read requests for 4 cycles -> grants alternate 0,1,0,1; rsp_valid_o follows the same order 1 cycle later.
- Concurrency: req0 writes 0x20 while req1 reads 0x20 in the same cycle -> both ready=1; req1 gets the old value; a read of 0x20 on the next cycle gets the new value.
- Write contention: both requesters write addr 0x30 with data 1 and 2 in cycle 0, held -> req0 granted in cycle 0, req1 in cycle 1; final RAM word = 2.
- Reset mid-read: read accepted in the same cycle rst_i=1 -> no rsp_valid_o in the following cycle; pointers back to 0.

Source files
------------

// File: rtl/ram_s2psbe1c_arb_pkg.sv
// Shared types and helpers for the byte-enable RAM arbiter.
// rr_pick: one-hot round-robin grant from a one-hot pointer and a candidate mask.
package ram_arb_pkg;

    // Widest requester count the helper function handles.
    localparam int MAX_REQ = 32;

    localparam logic [MAX_REQ-1:0] ONE = {{(MAX_REQ-1){1'b0}}, 1'b1};

    // Pick the first candidate at or above the pointer bit. If none is
    // found there, wrap around and pick the lowest candidate overall.
    // The pointer must be one-hot, and candidate bits above the real
    // requester count must be zero.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] ptr_oh,
        input logic [MAX_REQ-1:0] cand
    );
        logic [MAX_REQ-1:0] below;
        logic [MAX_REQ-1:0] hi;
        logic [MAX_REQ-1:0] sel;
        below = ptr_oh - ONE;
        hi    = cand & ~below;
        sel   = (|hi) ? hi : cand;
        // Isolate the lowest set bit.
        return sel & (~sel + ONE);
    endfunction

endpackage

// File: rtl/ram_s2psbe1c_arb_rr.sv
// Round-robin arbiter: one-hot priority pointer, combinational grant.
// Ports: clk_i, rst_i, req_i[N] candidates, gnt_o[N] one-hot grant.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    logic [N-1:0]       ptr_q;
    logic [MAX_REQ-1:0] ptr_w;
    logic [MAX_REQ-1:0] req_w;
    logic [MAX_REQ-1:0] gnt_w;
    logic               unused_gnt;

    always_comb begin
        ptr_w = '0;
        req_w = '0;
        ptr_w[N-1:0] = ptr_q;
        req_w[N-1:0] = req_i;
    end

    assign gnt_w      = rr_pick(ptr_w, req_w);
    assign gnt_o      = gnt_w[N-1:0];
    assign unused_gnt = ^gnt_w;

    // The pointer moves one past the winner, so the winner goes to the
    // back of the line. With no grant it holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= {{(N-1){1'b0}}, 1'b1};
        end else if (|gnt_o) begin
            ptr_q <= {gnt_o[N-2:0], gnt_o[N-1]};
        end
    end

endmodule

// File: rtl/ram_s2psbe1c_arb.sv
// Shares one simple-dual-port byte-enable RAM among N_REQ requesters:
// one write and one read grant per cycle, each class round-robin.
// Ports: req_* per-requester commands, req_ready_o combinational grant,
// rsp_valid_o/rsp_data_o read return, ram_* RAM write/read ports.
module ram_s2psbe1c_arb
    import ram_arb_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int BYTE_WIDTH    = 8,
    parameter int BYTES_IN_WORD = 4,
    parameter int WORD_COUNT    = 256
) (
    input  logic clk_i,
    input  logic rst_i,

    input  logic [N_REQ-1:0] req_valid_i,
    output logic [N_REQ-1:0] req_ready_o,
    input  logic [N_REQ-1:0] req_we_i,
    input  logic [N_REQ-1:0][BYTES_IN_WORD-1:0] req_be_i,
    input  logic [N_REQ-1:0][$clog2(WORD_COUNT)-1:0] req_addr_i,
    input  logic [N_REQ-1:0][BYTE_WIDTH*BYTES_IN_WORD-1:0] req_wdata_i,

    output logic [N_REQ-1:0] rsp_valid_o,
    output logic [BYTE_WIDTH*BYTES_IN_WORD-1:0] rsp_data_o,

    output logic ram_we_o,
    output logic [BYTES_IN_WORD-1:0] ram_be_o,
    output logic [$clog2(WORD_COUNT)-1:0] ram_waddr_o,
    output logic [BYTE_WIDTH*BYTES_IN_WORD-1:0] ram_wdata_o,
    output logic [$clog2(WORD_COUNT)-1:0] ram_raddr_o,
    input  logic [BYTE_WIDTH*BYTES_IN_WORD-1:0] ram_rdata_i
);

    localparam int ADDR_WIDTH = $clog2(WORD_COUNT);
    localparam int WORD_WIDTH = BYTE_WIDTH * BYTES_IN_WORD;

    typedef struct packed {
        logic                     we;
        logic [BYTES_IN_WORD-1:0] be;
        logic [ADDR_WIDTH-1:0]    addr;
        logic [WORD_WIDTH-1:0]    wdata;
    } req_t;

    req_t             req [N_REQ];
    logic [N_REQ-1:0] wr_cand;
    logic [N_REQ-1:0] rd_cand;
    logic [N_REQ-1:0] wr_gnt;
    logic [N_REQ-1:0] rd_gnt;
    logic [N_REQ-1:0] rd_sel_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign req[i] = '{
            we:    req_we_i[i],
            be:    req_be_i[i],
            addr:  req_addr_i[i],
            wdata: req_wdata_i[i]
        };
        assign wr_cand[i] = req_valid_i[i] & req[i].we;
        assign rd_cand[i] = req_valid_i[i] & ~req[i].we;
    end

    rr_arbiter #(.N(N_REQ)) u_wr_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (wr_cand),
        .gnt_o (wr_gnt)
    );

    rr_arbiter #(.N(N_REQ)) u_rd_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (rd_cand),
        .gnt_o (rd_gnt)
    );

    assign req_ready_o = wr_gnt | rd_gnt;

    // Grants are one-hot, so at most one branch fires. Idle drives zeros.
    always_comb begin
        ram_be_o    = '0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        ram_raddr_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (wr_gnt[i]) begin
                ram_be_o    = req[i].be;
                ram_waddr_o = req[i].addr;
                ram_wdata_o = req[i].wdata;
            end
            if (rd_gnt[i]) begin
                ram_raddr_o = req[i].addr;
            end
        end
    end

    assign ram_we_o = |wr_gnt;

    // Remembers which requester owns the data the RAM returns next cycle.
    // A read accepted while in reset is dropped here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_sel_q <= '0;
        end else begin
            rd_sel_q <= rd_gnt;
        end
    end

    assign rsp_valid_o = rd_sel_q;
    assign rsp_data_o  = ram_rdata_i;

    a_valid_known: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !$isunknown(req_valid_i));

    for (genvar i = 0; i < N_REQ; i++) begin : g_chk
        a_cmd_known: assert property (
            @(posedge clk_i) disable iff (rst_i)
            req_valid_i[i] |-> !$isunknown({req_we_i[i], req_addr_i[i]}));
        a_be_known: assert property (
            @(posedge clk_i) disable iff (rst_i)
            (req_valid_i[i] && req_we_i[i]) |-> !$isunknown(req_be_i[i]));
    end

    a_wr_onehot: assert property (
        @(posedge clk_i) disable iff (rst_i) $onehot0(wr_gnt));
    a_rd_onehot: assert property (
        @(posedge clk_i) disable iff (rst_i) $onehot0(rd_gnt));
    a_rsp_onehot: assert property (
        @(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid_o));

endmodule

// File: tb/tb_ram_s2psbe1c_arb.sv
// Directed bench for ram_s2psbe1c_arb with a behavioural byte-enable RAM.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_ram_s2psbe1c_arb;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][3:0]  req_be;
    logic [1:0][7:0]  req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_data;
    logic             ram_we;
    logic [3:0]       ram_be;
    logic [7:0]       ram_waddr;
    logic [31:0]      ram_wdata;
    logic [7:0]       ram_raddr;
    logic [31:0]      ram_rdata = '0;

    logic [31:0] mem [256] = '{default: '0};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_s2psbe1c_arb dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_be_i    (req_be),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .ram_raddr_o (ram_raddr),
        .ram_rdata_i (ram_rdata)
    );

    // Registered read returns pre-write data on a same-address collision.
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input int i, input logic we, input logic [3:0] be,
                       input logic [7:0] addr, input logic [31:0] wd);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_be[i]    = be;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
    endtask

    logic [1:0] fair_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        cyc();
        cyc();
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_ram_we", 64'(ram_we), 64'h0);
        chk("rst_ram_be", 64'(ram_be), 64'h0);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("idle_waddr", 64'(ram_waddr), 64'h0);
        rst = 1'b0;

        // Byte-enabled write then read-back by requester 0.
        drv(0, 1'b1, 4'b0101, 8'h10, 32'hAABBCCDD);
        #1;
        chk("wr_ready", 64'(req_ready), 64'h1);
        chk("wr_we", 64'(ram_we), 64'h1);
        chk("wr_be", 64'(ram_be), 64'h5);
        chk("wr_addr", 64'(ram_waddr), 64'h10);
        chk("wr_data", 64'(ram_wdata), 64'hAABBCCDD);
        cyc();
        idle();
        drv(0, 1'b0, 4'b0000, 8'h10, 32'h0);
        #1;
        chk("rd_ready", 64'(req_ready), 64'h1);
        chk("rd_raddr", 64'(ram_raddr), 64'h10);
        chk("rd_no_we", 64'(ram_we), 64'h0);
        cyc();
        idle();
        #1;
        chk("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rd_rsp_data", 64'(rsp_data), 64'h00BB00DD);

        // Read accepted while in reset is dropped.
        rst = 1'b1;
        drv(0, 1'b0, 4'b0000, 8'h10, 32'h0);
        #1;
        chk("rstrd_ready", 64'(req_ready), 64'h1);
        cyc();
        rst = 1'b0;
        idle();
        #1;
        chk("rstrd_no_rsp", 64'(rsp_valid), 64'h0);

        // Two readers alternate, starting at requester 0.
        drv(0, 1'b0, 4'b0000, 8'h10, 32'h0);
        drv(1, 1'b0, 4'b0000, 8'h11, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("fair_ready%0d", k), 64'(req_ready),
                64'(fair_exp[k]));
            if (k > 0) begin
                chk($sformatf("fair_rsp%0d", k), 64'(rsp_valid),
                    64'(fair_exp[k-1]));
                chk($sformatf("fair_data%0d", k), 64'(rsp_data),
                    (fair_exp[k-1] == 2'b01) ? 64'h00BB00DD : 64'h0);
            end
            cyc();
        end
        idle();
        #1;
        chk("fair_rsp_last", 64'(rsp_valid), 64'h2);
        chk("fair_data_last", 64'(rsp_data), 64'h0);

        // Same-address write and read in one cycle: read sees old data.
        drv(0, 1'b1, 4'b1111, 8'h20, 32'h12345678);
        drv(1, 1'b0, 4'b0000, 8'h20, 32'h0);
        #1;
        chk("cc_ready", 64'(req_ready), 64'h3);
        chk("cc_we", 64'(ram_we), 64'h1);
        chk("cc_raddr", 64'(ram_raddr), 64'h20);
        chk("cc_waddr", 64'(ram_waddr), 64'h20);
        cyc();
        idle();
        drv(1, 1'b0, 4'b0000, 8'h20, 32'h0);
        #1;
        chk("cc_rsp_old", 64'(rsp_valid), 64'h2);
        chk("cc_data_old", 64'(rsp_data), 64'h0);
        cyc();
        idle();
        #1;
        chk("cc_rsp_new", 64'(rsp_valid), 64'h2);
        chk("cc_data_new", 64'(rsp_data), 64'h12345678);

        // Reset to restore pointers, then two writers contend.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drv(0, 1'b1, 4'b1111, 8'h30, 32'h1);
        drv(1, 1'b1, 4'b1111, 8'h30, 32'h2);
        #1;
        chk("wc_ready0", 64'(req_ready), 64'h1);
        chk("wc_wdata0", 64'(ram_wdata), 64'h1);
        cyc();
        req_valid[0] = 1'b0;
        #1;
        chk("wc_ready1", 64'(req_ready), 64'h2);
        chk("wc_wdata1", 64'(ram_wdata), 64'h2);
        cyc();
        idle();
        drv(0, 1'b0, 4'b0000, 8'h30, 32'h0);
        #1;
        chk("wc_rd_ready", 64'(req_ready), 64'h1);
        cyc();
        idle();
        // be=0 write is forwarded but changes nothing.
        drv(1, 1'b1, 4'b0000, 8'h30, 32'hFFFFFFFF);
        #1;
        chk("wc_rsp", 64'(rsp_valid), 64'h1);
        chk("wc_final", 64'(rsp_data), 64'h2);
        chk("be0_ready", 64'(req_ready), 64'h2);
        chk("be0_we", 64'(ram_we), 64'h1);
        chk("be0_be", 64'(ram_be), 64'h0);
        cyc();
        idle();
        drv(1, 1'b0, 4'b0000, 8'h30, 32'h0);
        #1;
        chk("be0_rd_ready", 64'(req_ready), 64'h2);
        cyc();
        idle();
        #1;
        chk("be0_rsp", 64'(rsp_valid), 64'h2);
        chk("be0_data", 64'(rsp_data), 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
